// File: rtl/mult8_pkg.sv
// Shared types and step decode for the 8x8 sequential multiplier sequencer.
// Optional zero-operand fast path is enabled by defining MULT8_ZERO_SKIP_EN.
package mult8_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] SH0 = 2'b00;
    localparam logic [1:0] SH4 = 2'b01;
    localparam logic [1:0] SH8 = 2'b10;

    localparam int NSTEPS = 4;

    typedef struct packed {
        logic       aSel;
        logic       bSel;
        logic [1:0] shift;
    } step_cfg_t;

    // Step order: lo*lo, hi*lo, lo*hi, hi*hi (sel 0 = low nibble, 1 = high nibble)
    function automatic step_cfg_t stepLookup(input logic [1:0] step);
        step_cfg_t cfg;
        case (step)
            2'd0:    cfg = '{aSel: 1'b0, bSel: 1'b0, shift: SH0};
            2'd1:    cfg = '{aSel: 1'b1, bSel: 1'b0, shift: SH4};
            2'd2:    cfg = '{aSel: 1'b0, bSel: 1'b1, shift: SH4};
            default: cfg = '{aSel: 1'b1, bSel: 1'b1, shift: SH8};
        endcase
        return cfg;
    endfunction

    function automatic logic [3:0] nibble(input logic [7:0] value, input logic sel);
        return sel ? value[7:4] : value[3:0];
    endfunction

endpackage

// File: rtl/mult8_seq_ctrl_shifter.sv
// Places an 8-bit nibble product at bit 0, 4 or 8 of a 16-bit word.
module mult8_seq_ctrl_shifter
    import mult8_pkg::*;
(
    input  logic [7:0]  inp,
    input  logic [1:0]  shift_cntrl,
    output logic [15:0] shift_out
);

    always_comb begin
        shift_out = '0;
        case (shift_cntrl)
            SH0:     shift_out = {8'h00, inp};
            SH4:     shift_out = {4'h0, inp, 4'h0};
            SH8:     shift_out = {inp, 8'h00};
            default: shift_out = '0;
        endcase
    end

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequencer stepping an external 4x4 multiplier through four nibble products into a 16-bit product.
// Define MULT8_ZERO_SKIP_EN to finish zero-operand requests immediately without entering CALC.
module mult8_seq_ctrl
    import mult8_pkg::*;
#(
    parameter int DONE_PULSE = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  dataa,
    input  logic [7:0]  datab,
    output logic [3:0]  mult4_a,
    output logic [3:0]  mult4_b,
    input  logic [7:0]  mult4_p,
    output logic [1:0]  shift_cntrl,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    state_t      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [7:0]  opA_q, opA_d;
    logic [7:0]  opB_q, opB_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] product_q, product_d;
    logic        done_q, done_d;
    logic [3:0]  multA_q, multA_d;
    logic [3:0]  multB_q, multB_d;
    logic [1:0]  shift_q, shift_d;
    logic [15:0] shiftOut;
    logic [15:0] accSum;
    logic        zeroSkip;
    step_cfg_t   firstCfg;
    step_cfg_t   nextCfg;

    mult8_seq_ctrl_shifter uShifter (
        .inp         (mult4_p),
        .shift_cntrl (shift_q),
        .shift_out   (shiftOut)
    );

    assign accSum   = acc_q + shiftOut;
    assign firstCfg = stepLookup(2'd0);
    assign nextCfg  = stepLookup(step_q + 2'd1);

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        acc_d     = acc_q;
        product_d = product_q;
        done_d    = done_q;
        multA_d   = multA_q;
        multB_d   = multB_q;
        shift_d   = shift_q;
`ifdef MULT8_ZERO_SKIP_EN
        zeroSkip  = (dataa == 8'h00) || (datab == 8'h00);
`else
        zeroSkip  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    opA_d  = dataa;
                    opB_d  = datab;
                    acc_d  = '0;
                    step_d = '0;
                    done_d = 1'b0;
                    if (zeroSkip) begin
                        state_d   = DONE;
                        product_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        // Step-0 nibbles come straight from the inputs so the first product is ready in t1
                        state_d = CALC;
                        multA_d = nibble(dataa, firstCfg.aSel);
                        multB_d = nibble(datab, firstCfg.bSel);
                        shift_d = firstCfg.shift;
                    end
                end
            end
            CALC: begin
                acc_d = accSum;
                if (step_q == 2'(NSTEPS - 1)) begin
                    state_d   = DONE;
                    product_d = accSum;
                    done_d    = 1'b1;
                    multA_d   = '0;
                    multB_d   = '0;
                    shift_d   = SH0;
                end else begin
                    step_d  = step_q + 2'd1;
                    multA_d = nibble(opA_q, nextCfg.aSel);
                    multB_d = nibble(opB_q, nextCfg.bSel);
                    shift_d = nextCfg.shift;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (DONE_PULSE != 0) begin
                    done_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            step_q    <= '0;
            opA_q     <= '0;
            opB_q     <= '0;
            acc_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            multA_q   <= '0;
            multB_q   <= '0;
            shift_q   <= SH0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            done_q    <= done_d;
            multA_q   <= multA_d;
            multB_q   <= multB_d;
            shift_q   <= shift_d;
        end
    end

    assign mult4_a     = multA_q;
    assign mult4_b     = multB_q;
    assign shift_cntrl = shift_q;
    assign busy        = (state_q == CALC);
    assign done        = done_q;
    assign product     = product_q;

endmodule
